// File: rtl/multi_rate_divider_pkg.sv
// multi_rate_divider_pkg: shared defaults and the smallest legal divisor
package multi_rate_divider_pkg;
  localparam int DFLT_CLK_HZ = 100_000_000;
  localparam int DFLT_DEF_HZ = 100;
  localparam int DFLT_CNT_W = 27;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/multi_rate_divider_div_channel.sv
// div_channel: one counter-based divider with boundary-aligned divisor reload
module div_channel
  import multi_rate_divider_pkg::*;
#(
  parameter int CNT_W = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DFLT_CLK_HZ / DFLT_DEF_HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clkout,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_d, cnt_q, act_d, act_q, pend_div_d, pend_div_q;
  logic pend_d, pend_q, clkout_d, clkout_q, tick_d, tick_q, wrap, direct;
  always_comb begin
    wrap = en && (cnt_q == act_q - 1'b1);
    direct = wr && (sync || !en || wrap);
    cnt_d = (en && !sync && !wrap) ? cnt_q + 1'b1 : '0;
    act_d = direct ? wr_div : ((sync || wrap) && pend_q) ? pend_div_q : act_q;
    pend_div_d = wr ? wr_div : pend_div_q;
    pend_d = wr ? !direct : (pend_q && !sync && !wrap);
    clkout_d = en && (cnt_d >= (act_d >> 1));
    tick_d = wrap && !sync;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      act_q <= DEF_DIV;
      pend_div_q <= DEF_DIV;
      pend_q <= 1'b0;
      clkout_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      pend_div_q <= pend_div_d;
      pend_q <= pend_d;
      clkout_q <= clkout_d;
      tick_q <= tick_d;
    end
  end
  assign clkout = clkout_q;
  assign tick = tick_q;
endmodule

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: N_CH programmable dividers sharing one write port and sync
module multi_rate_divider
  import multi_rate_divider_pkg::*;
#(
  parameter int CLK_HZ = DFLT_CLK_HZ,
  parameter int N_CH = 4,
  parameter int CNT_W = DFLT_CNT_W,
  parameter int DEF_HZ = DFLT_DEF_HZ,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  clkout,
  output logic [N_CH-1:0]  tick,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(CLK_HZ / DEF_HZ);
  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);
  logic ch_ok, div_low, cfg_err_d, cfg_err_q;
  logic [CNT_W-1:0] wr_div;
  always_comb begin
    ch_ok = {1'b0, cfg_ch} < (CH_W + 1)'(N_CH);
    div_low = cfg_div < MIN_D;
    wr_div = div_low ? MIN_D : cfg_div;
    cfg_err_d = cfg_we && (!ch_ok || div_low);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else cfg_err_q <= cfg_err_d;
  end
  assign cfg_err = cfg_err_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    div_channel #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[i]),
      .sync(sync),
      .wr(cfg_we && ch_ok && cfg_ch == CH_W'(i)),
      .wr_div(wr_div),
      .clkout(clkout[i]),
      .tick(tick[i])
    );
  end
endmodule

// File: tb/tb_multi_rate_divider.sv
// tb_multi_rate_divider: scoreboarded tick/clkout checks across divider scenarios
module tb_multi_rate_divider;
  localparam int N_CH = 3;
  localparam int CNT_W = 16;
  localparam int CH_W = 2;
  logic clk = 1'b0, rst_n = 1'b0, sync = 1'b0, cfg_we = 1'b0, cfg_err;
  logic [N_CH-1:0] en = '0, clkout, tick;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  int cyc = 0, checks = 0, errors = 0, r = 0;
  int exp_q[$];
  int org[N_CH], dd[N_CH];
  logic [N_CH-1:0] mask = '0;

  multi_rate_divider #(.CLK_HZ(1000), .N_CH(N_CH), .CNT_W(CNT_W), .DEF_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clkout(clkout), .tick(tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ticks(int ch, int first, int period, int n);
    for (int i = 0; i < n; i++) exp_q.push_back((first + i * period) * 16 + ch);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < N_CH; ch++) begin
        if (mask[ch]) begin
          logic want_clk;
          int idx;
          want_clk = dd[ch] != 0 && ((cyc - org[ch]) % dd[ch]) >= dd[ch] / 2;
          checks++;
          if (clkout[ch] !== want_clk) begin
            errors++;
            $display("FAIL clkout ch%0d cyc=%0d got=%b want=%b", ch, cyc, clkout[ch], want_clk);
          end
          idx = -1;
          foreach (exp_q[j]) if (exp_q[j] == cyc * 16 + ch) idx = j;
          checks++;
          if (tick[ch] !== (idx >= 0)) begin
            errors++;
            $display("FAIL tick ch%0d cyc=%0d got=%b want=%b", ch, cyc, tick[ch], idx >= 0);
          end
          if (idx >= 0) exp_q.delete(idx);
        end
      end
    end
  endtask

  task automatic drain(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_ticks got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(string name);
    checks++;
    if ({clkout, tick, cfg_err} !== '0) begin
      errors++;
      $display("FAIL %s outputs got=%b want=0", name, {clkout, tick, cfg_err});
    end
  endtask

  task automatic check_err(string name, logic want);
    checks++;
    if (cfg_err !== want) begin
      errors++;
      $display("FAIL %s cfg_err got=%b want=%b", name, cfg_err, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = '1; sync = 1'b1; cfg_we = 1'b1; cfg_ch = 0; cfg_div = 3;
    repeat (2) @(negedge clk);
    check_idle("reset_override");
    sync = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1'b1; r = cyc;
    for (int ch = 0; ch < N_CH; ch++) begin
      org[ch] = r; dd[ch] = 10;
      push_ticks(ch, r + 10, 10, 3);
    end
    mask = '1;
    run(32);
    drain("reset_release");
  endtask

  task automatic test_reconfig;
    mask = 3'b001;
    run(1);
    cfg_we = 1'b1; cfg_ch = 0; cfg_div = 7;
    run(1);
    check_err("valid_write", 1'b0);
    cfg_we = 1'b0;
    push_ticks(0, r + 40, 7, 4);
    run(6);
    org[0] = r + 40; dd[0] = 7;
    run(22);
    drain("reconfig");
  endtask

  task automatic test_clamp;
    mask = 3'b010;
    run(1);
    cfg_we = 1'b1; cfg_ch = 1; cfg_div = 1;
    run(1);
    check_err("clamp_pulse", 1'b1);
    cfg_we = 1'b0;
    run(1);
    check_err("clamp_one_cycle", 1'b0);
    push_ticks(1, r + 70, 2, 5);
    run(5);
    org[1] = r + 70; dd[1] = 2;
    run(8);
    cfg_we = 1'b1; cfg_ch = 3; cfg_div = 5;
    run(1);
    check_err("bad_channel", 1'b1);
    cfg_we = 1'b0;
    mask = '1;
    push_ticks(0, r + 82, 7, 2);
    push_ticks(1, r + 80, 2, 6);
    push_ticks(2, r + 80, 10, 2);
    run(11);
    drain("clamp_no_change");
  endtask

  task automatic test_sync;
    int s1;
    mask = '0;
    cfg_we = 1'b1; cfg_ch = 0; cfg_div = 6; sync = 1'b1;
    run(1);
    cfg_ch = 1; cfg_div = 9; sync = 1'b0;
    run(1);
    cfg_we = 1'b0;
    run(3);
    sync = 1'b1;
    s1 = cyc + 1;
    org[0] = s1; dd[0] = 6; org[1] = s1; dd[1] = 9;
    push_ticks(0, s1 + 6, 6, 3);
    push_ticks(1, s1 + 9, 9, 2);
    mask = 3'b011;
    run(1);
    sync = 1'b0;
    run(19);
    drain("sync");
  endtask

  task automatic test_enable;
    mask = '0;
    for (int i = 0; i < 10 && ((cyc - org[2]) % 10) != 6; i++) run(1);
    en[2] = 1'b0; dd[2] = 0; mask = 3'b100;
    run(20);
    en[2] = 1'b1; org[2] = cyc; dd[2] = 10;
    push_ticks(2, cyc + 10, 10, 2);
    run(22);
    drain("reenable");
  endtask

  task automatic test_reset_pending;
    mask = '0;
    cfg_we = 1'b1; cfg_ch = 0; cfg_div = 4;
    run(1);
    cfg_we = 1'b0; rst_n = 1'b0;
    run(1);
    check_idle("reset_pending");
    rst_n = 1'b1;
    for (int ch = 0; ch < N_CH; ch++) begin
      org[ch] = cyc; dd[ch] = 10;
      push_ticks(ch, cyc + 10, 10, 2);
    end
    mask = '1;
    run(22);
    drain("reset_pending_period");
  endtask

  initial begin
    test_reset;
    test_reconfig;
    test_clamp;
    test_sync;
    test_enable;
    test_reset_pending;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
